regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Write-back end of the operand path: owns the LC-3b 8x16 general register file, the NZP condition codes, and a per-register pending-write scoreboard.
- Decode reads source operands from it; those values feed the decode-to-execute operand latch.
- The MEM/WB stage writes results back into it.
- Provides same-cycle write-through bypass and busy flags, so decode can stall on outstanding writes.

Parameters:
- NREG, 8, number of architectural registers; index width is clog2(NREG) = 3.
- PCNT_W, 2, width of each per-register pending-write counter (maximum 2^PCNT_W - 1 outstanding writes).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  write-back strobe from MEM/WB.
- wb_dest  input  3  write-back destination register.
- wb_data  input  16  write-back data (lc3b_word).
- wb_setcc  input  1  update NZP from wb_data; qualified by wb_valid.
- issue_valid  input  1  decode issues an instruction that will write issue_dest.
- issue_dest  input  3  destination register being reserved.
- issue_stall  output  1  issue refused: issue_dest counter saturated.
- sr1, sr2  input  3 each  source register indices.
- sr1_data, sr2_data  output  16 each  source operand values.
- sr1_busy, sr2_busy  output  1 each  source still has a pending write after this cycle's write-back.
- nzp  output  3  condition codes {N,Z,P}.
- sb_err  output  1  sticky scoreboard underflow error.

Behaviour:
Reset:
- Asserting reset at any time, including mid-operation, immediately sets all registers to 0x0000, nzp to 3'b010, all counters to 0, and sb_err to 0.
- Outputs reflect these values while reset is high.

Write port:
- On a rising edge with wb_valid=1, regs[wb_dest] <= wb_data.
- Single write port; no write conflicts are possible.

NZP:
- On a rising edge with wb_valid=1 and wb_setcc=1: nzp <= 100 if wb_data[15]=1; 010 if wb_data=0; otherwise 001.
- wb_setcc with wb_valid=0 is ignored.

Read ports (combinational, zero latency):
- srN_data = wb_data when wb_valid=1 and wb_dest=srN (write-through bypass); otherwise regs[srN].
- Both ports may name the same register.

Scoreboard:
- cnt[r] counts outstanding writes to register r.
- inc = issue_valid and not issue_stall. dec = wb_valid.
- Same register hit by both inc and dec in one cycle: cnt unchanged.
- Different registers: each updates independently.
- issue_stall = issue_valid and cnt[issue_dest] = all-ones. The issue is dropped and the counter holds. Combinational.
- dec on a counter that is 0: counter stays 0, sb_err <= 1. sb_err stays 1 until reset.

Busy:
- srN_busy = (cnt[srN] - (wb_valid and wb_dest=srN ? 1 : 0)) != 0, evaluated on current-cycle values.
- An issue in the same cycle does not set busy until the next cycle.
- Register 0 has no special meaning; all 8 registers are writable.

Timing: all state updates occur on the rising edge; there are no multi-cycle operations.

Test Plan:
1. Reset then idle: all srN_data = 0x0000, nzp = 010, busy = 0, sb_err = 0; assert reset mid-stream after writes and confirm the same values immediately.
2. Write R3 = 0x8001 with setcc: same cycle sr1=3 reads 0x8001 via bypass; next cycle reads 0x8001 from the array and nzp = 100. Repeat with 0x0000 -> 010 and 0x0005 -> 001. Write with setcc=1 but wb_valid=0 -> no change.
3. Issue R5 twice on consecutive cycles -> cnt = 2 and sr2_busy = 1. Write-back R5 once -> busy stays 1. Second write-back -> sr2_busy = 0 in the same cycle.
4. Issue R2 three times (cnt = 3), then a fourth issue -> issue_stall = 1 and cnt stays 3. Simultaneous issue R2 with write-back R2 at cnt = 3 -> issue_stall = 1, so the issue is dropped and cnt becomes 2.
5. cnt[R4] = 1, simultaneous issue R4 and write-back R4 -> cnt stays 1 and busy = 1 next cycle. Issue R1 with write-back R6 in the same cycle -> R1 = 1, R6 decremented.
6. Write-back R7 with cnt = 0 -> register written, sb_err = 1 and held across later traffic; cleared only by reset.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: write-back end of the operand path.
// Holds the 8x16 general register file, the NZP condition codes and a
// per-register pending-write scoreboard.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   wb_valid/dest/data      write-back port from MEM/WB
//   wb_setcc                update NZP from wb_data (only with wb_valid)
//   issue_valid/dest        decode reserves a pending write to issue_dest
//   issue_stall             issue refused: destination counter saturated
//   sr1, sr2                source register indices
//   sr1_data, sr2_data      operand values with same-cycle write-through
//   sr1_busy, sr2_busy      source still has a pending write after this cycle
//   nzp                     condition codes {N,Z,P}
//   sb_err                  sticky scoreboard underflow flag
module regfile_wb #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned PCNT_W = 2,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_dest,
  input  logic [15:0]      wb_data,
  input  logic             wb_setcc,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_dest,
  output logic             issue_stall,
  input  logic [IDX_W-1:0] sr1,
  input  logic [IDX_W-1:0] sr2,
  output logic [15:0]      sr1_data,
  output logic [15:0]      sr2_data,
  output logic             sr1_busy,
  output logic             sr2_busy,
  output logic [2:0]       nzp,
  output logic             sb_err
);

  logic [15:0]       regs_q [NREG];
  logic [PCNT_W-1:0] cnt_q  [NREG];
  logic [PCNT_W-1:0] cnt_d  [NREG];
  logic [2:0]        nzp_q, nzp_d;
  logic              sb_err_q, sb_err_d;
  logic              inc;

  // An issue to a saturated counter is dropped, even if a write-back to the
  // same register would free a slot this cycle.
  assign issue_stall = issue_valid && (cnt_q[issue_dest] == {PCNT_W{1'b1}});
  assign inc         = issue_valid && !issue_stall;

  // Read ports with write-through bypass.
  assign sr1_data = (wb_valid && (wb_dest == sr1)) ? wb_data : regs_q[sr1];
  assign sr2_data = (wb_valid && (wb_dest == sr2)) ? wb_data : regs_q[sr2];

  // Busy reflects the count after this cycle's write-back, ignoring any issue.
  assign sr1_busy = cnt_q[sr1] !=
                    ((wb_valid && (wb_dest == sr1)) ? PCNT_W'(1) : PCNT_W'(0));
  assign sr2_busy = cnt_q[sr2] !=
                    ((wb_valid && (wb_dest == sr2)) ? PCNT_W'(1) : PCNT_W'(0));

  assign nzp    = nzp_q;
  assign sb_err = sb_err_q;

  always_comb begin
    nzp_d = nzp_q;
    if (wb_valid && wb_setcc) begin
      if (wb_data[15])          nzp_d = 3'b100;
      else if (wb_data == '0)   nzp_d = 3'b010;
      else                      nzp_d = 3'b001;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      // Inc and dec on the same register cancel out.
      if (inc && (issue_dest == IDX_W'(r)) &&
          !(wb_valid && (wb_dest == IDX_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + PCNT_W'(1);
      end else if (wb_valid && (wb_dest == IDX_W'(r)) &&
                   !(inc && (issue_dest == IDX_W'(r)))) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      nzp_q    <= 3'b010;
      sb_err_q <= 1'b0;
    end else begin
      if (wb_valid) regs_q[wb_dest] <= wb_data;
      cnt_q    <= cnt_d;
      nzp_q    <= nzp_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb. Inputs change 1 ns after the rising edge;
// outputs are sampled 1 ns later, well before the next edge.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_setcc;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic        issue_stall;
  logic [2:0]  sr1, sr2;
  logic [15:0] sr1_data, sr2_data;
  logic        sr1_busy, sr2_busy;
  logic [2:0]  nzp;
  logic        sb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .wb_setcc    (wb_setcc),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_stall (issue_stall),
    .sr1         (sr1),
    .sr2         (sr2),
    .sr1_data    (sr1_data),
    .sr2_data    (sr2_data),
    .sr1_busy    (sr1_busy),
    .sr2_busy    (sr2_busy),
    .nzp         (nzp),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid    = 1'b0;
    wb_setcc    = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic set_wb(input logic [2:0] d, input logic [15:0] v, input logic cc);
    wb_valid = 1'b1;
    wb_dest  = d;
    wb_data  = v;
    wb_setcc = cc;
  endtask

  task automatic set_issue(input logic [2:0] d);
    issue_valid = 1'b1;
    issue_dest  = d;
  endtask

  initial begin
    reset = 1'b1;
    wb_dest = '0; wb_data = '0; issue_dest = '0;
    sr1 = 3'd0; sr2 = 3'd1;
    idle();
    #1;
    // 1. Reset state
    check("rst_sr1_data", sr1_data, 16'h0000);
    check("rst_sr2_data", sr2_data, 16'h0000);
    check("rst_nzp", 16'(nzp), 16'h2);
    check("rst_busy", 16'({sr1_busy, sr2_busy}), 16'h0);
    check("rst_sb_err", 16'(sb_err), 16'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_nzp", 16'(nzp), 16'h2);

    // 2. Write-back with bypass and NZP
    sr1 = 3'd3;
    set_issue(3'd3); tick(); idle();
    set_wb(3'd3, 16'h8001, 1'b1); #1;
    check("bypass_8001", sr1_data, 16'h8001);
    check("nzp_before_edge", 16'(nzp), 16'h2);
    tick(); idle(); #1;
    check("array_8001", sr1_data, 16'h8001);
    check("nzp_neg", 16'(nzp), 16'h4);
    set_issue(3'd3); tick(); idle();
    set_wb(3'd3, 16'h0000, 1'b1); tick(); idle(); #1;
    check("array_0000", sr1_data, 16'h0000);
    check("nzp_zero", 16'(nzp), 16'h2);
    set_issue(3'd3); tick(); idle();
    set_wb(3'd3, 16'h0005, 1'b1); tick(); idle(); #1;
    check("array_0005", sr1_data, 16'h0005);
    check("nzp_pos", 16'(nzp), 16'h1);
    // setcc without wb_valid is ignored
    wb_dest = 3'd3; wb_data = 16'h8000; wb_setcc = 1'b1; #1;
    check("novalid_bypass", sr1_data, 16'h0005);
    tick(); idle(); #1;
    check("novalid_reg", sr1_data, 16'h0005);
    check("novalid_nzp", 16'(nzp), 16'h1);
    check("sb_err_clean", 16'(sb_err), 16'h0);

    // 3. Two issues to R5, two write-backs
    sr2 = 3'd5;
    set_issue(3'd5); #1;
    check("r5_busy_issue_cycle", 16'(sr2_busy), 16'h0);
    tick(); tick(); idle(); #1;
    check("r5_busy_cnt2", 16'(sr2_busy), 16'h1);
    set_wb(3'd5, 16'h1234, 1'b0); #1;
    check("r5_busy_wb1", 16'(sr2_busy), 16'h1);
    tick(); idle(); #1;
    check("r5_busy_cnt1", 16'(sr2_busy), 16'h1);
    set_wb(3'd5, 16'h5678, 1'b0); #1;
    check("r5_busy_wb2", 16'(sr2_busy), 16'h0);
    check("r5_bypass", sr2_data, 16'h5678);
    tick(); idle(); #1;
    check("r5_busy_cnt0", 16'(sr2_busy), 16'h0);
    check("r5_data", sr2_data, 16'h5678);

    // 4. Saturation on R2
    sr1 = 3'd2;
    set_issue(3'd2); #1;
    check("r2_stall_c0", 16'(issue_stall), 16'h0);
    tick(); #1;
    check("r2_stall_c1", 16'(issue_stall), 16'h0);
    tick(); #1;
    check("r2_stall_c2", 16'(issue_stall), 16'h0);
    tick(); #1;
    check("r2_stall_c3", 16'(issue_stall), 16'h1);
    tick(); #1;  // dropped issue, cnt holds at 3
    check("r2_stall_hold", 16'(issue_stall), 16'h1);
    set_wb(3'd2, 16'h0002, 1'b0); #1;
    check("r2_stall_with_wb", 16'(issue_stall), 16'h1);
    check("r2_busy_with_wb", 16'(sr1_busy), 16'h1);
    tick(); idle();
    set_issue(3'd2); #1;  // cnt now 2
    check("r2_stall_cnt2", 16'(issue_stall), 16'h0);
    tick(); #1;
    check("r2_stall_refill", 16'(issue_stall), 16'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      set_wb(3'd2, 16'(16'h0020 + i), 1'b0); tick(); idle();
    end
    #1;
    check("r2_drained_busy", 16'(sr1_busy), 16'h0);
    check("r2_data", sr1_data, 16'h0022);

    // 5. Simultaneous inc/dec
    sr1 = 3'd4;
    set_issue(3'd4); tick(); idle();
    set_issue(3'd4); set_wb(3'd4, 16'h0444, 1'b0); tick(); idle(); #1;
    check("r4_busy_same", 16'(sr1_busy), 16'h1);
    set_issue(3'd6); tick(); idle();
    sr1 = 3'd1; sr2 = 3'd6;
    set_issue(3'd1); set_wb(3'd6, 16'h0666, 1'b0); tick(); idle(); #1;
    check("r1_busy_inc", 16'(sr1_busy), 16'h1);
    check("r6_busy_dec", 16'(sr2_busy), 16'h0);
    check("r6_data", sr2_data, 16'h0666);
    set_wb(3'd4, 16'h0445, 1'b0); tick(); idle();
    set_wb(3'd1, 16'h0111, 1'b0); tick(); idle(); #1;
    check("r1_busy_done", 16'(sr1_busy), 16'h0);
    check("sb_err_still_clean", 16'(sb_err), 16'h0);

    // 6. Underflow on R7
    sr1 = 3'd7; sr2 = 3'd0;
    set_wb(3'd7, 16'h0777, 1'b0); tick(); idle(); #1;
    check("r7_data", sr1_data, 16'h0777);
    check("sb_err_set", 16'(sb_err), 16'h1);
    check("r7_busy", 16'(sr1_busy), 16'h0);
    set_issue(3'd0); tick(); idle();
    set_wb(3'd0, 16'h0abc, 1'b0); tick(); idle(); #1;
    check("r0_data", sr2_data, 16'h0abc);
    check("sb_err_sticky", 16'(sb_err), 16'h1);

    // 1b. Mid-stream asynchronous reset
    set_issue(3'd5); tick(); idle(); #2;
    reset = 1'b1; #1;
    check("mrst_sr1", sr1_data, 16'h0000);
    check("mrst_sr2", sr2_data, 16'h0000);
    check("mrst_nzp", 16'(nzp), 16'h2);
    check("mrst_sb_err", 16'(sb_err), 16'h0);
    sr1 = 3'd3; sr2 = 3'd5; #1;
    check("mrst_r3", sr1_data, 16'h0000);
    check("mrst_r5_busy", 16'(sr2_busy), 16'h0);
    tick();
    reset = 1'b0;
    tick(); #1;
    check("post_rst_sb_err", 16'(sb_err), 16'h0);
    check("post_rst_r3", sr1_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
